adxl362_spi_sequencer: RTL

Sequences all traffic to the ADXL362 accelerometer over a byte-level SPI master. After reset it performs the sensor bring-up (soft reset, then measurement-mode enable), then issues periodic burst reads of XDATA/YDATA at UPDATE_FREQUENCY_HZ and publishes both axes atomically. It owns chip-select framing, inter-frame gaps and a per-byte timeout with automatic re-initialisation. It sits between the SPI byte engine (which drives SCLK/MOSI/MISO) and the accelerometer consumers on the SoC.

---
 rtl/adxl362_spi_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/adxl362_spi_sequencer.sv
// ADXL362 bring-up and periodic XDATA/YDATA burst reader on top of a
// byte-level SPI engine; owns CS framing, gaps, update timing and timeouts.
module adxl362_spi_sequencer #(
    parameter int SYSCLK_FREQUENCY_HZ    = 100000000,
    parameter int UPDATE_FREQUENCY_HZ    = 1000,
    parameter int SOFT_RESET_WAIT_CYCLES = 50000,
    parameter int CS_GAP_CYCLES          = 10,
    parameter int TIMEOUT_CYCLES         = 4096
) (
    input  logic       clk,
    input  logic       reset,
    output logic       spi_start,
    output logic [7:0] spi_tx_byte,
    input  logic       spi_busy,
    input  logic       spi_done,
    input  logic [7:0] spi_rx_byte,
    output logic       spi_cs,
    output logic [7:0] x_accel,
    output logic [7:0] y_accel,
    output logic       sample_valid,
    output logic       config_done,
    output logic       error
);

    localparam int PERIOD   = SYSCLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ;
    localparam int PW       = $clog2(PERIOD + 1);
    localparam int WAIT_MAX = (SOFT_RESET_WAIT_CYCLES > CS_GAP_CYCLES) ?
                              SOFT_RESET_WAIT_CYCLES : CS_GAP_CYCLES;
    localparam int WW       = $clog2(WAIT_MAX + 1);
    localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_CS_SETUP   = 3'd0;
    localparam logic [2:0] S_SEND       = 3'd1;
    localparam logic [2:0] S_WAIT_DONE  = 3'd2;
    localparam logic [2:0] S_CS_RELEASE = 3'd3;
    localparam logic [2:0] S_GAP        = 3'd4;
    localparam logic [2:0] S_WAIT_SR    = 3'd5;
    localparam logic [2:0] S_WAIT_TICK  = 3'd6;

    localparam logic [1:0] FR_SR  = 2'd0;
    localparam logic [1:0] FR_PWR = 2'd1;
    localparam logic [1:0] FR_RD  = 2'd2;

    logic [2:0]    state;
    logic [1:0]    frame;
    logic [1:0]    byte_idx;
    logic [WW-1:0] wait_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [PW-1:0] tick_cnt;
    logic          pending;
    logic [7:0]    x_buf;
    logic          tick;
    logic          last_byte;
    logic          tmo_hit;

    function automatic logic [7:0] frame_byte(input logic [1:0] fr,
                                              input logic [1:0] idx);
        case ({fr, idx})
            {FR_SR, 2'd0}:  frame_byte = 8'h0A;
            {FR_SR, 2'd1}:  frame_byte = 8'h1F;
            {FR_SR, 2'd2}:  frame_byte = 8'h52;
            {FR_PWR, 2'd0}: frame_byte = 8'h0A;
            {FR_PWR, 2'd1}: frame_byte = 8'h2D;
            {FR_PWR, 2'd2}: frame_byte = 8'h02;
            {FR_RD, 2'd0}:  frame_byte = 8'h0B;
            {FR_RD, 2'd1}:  frame_byte = 8'h08;
            default:        frame_byte = 8'h00;
        endcase
    endfunction

    assign tick      = config_done && (tick_cnt == PW'(PERIOD - 1));
    assign last_byte = byte_idx == ((frame == FR_RD) ? 2'd3 : 2'd2);
    assign tmo_hit   = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_CS_SETUP;
            frame        <= FR_SR;
            byte_idx     <= 2'd0;
            wait_cnt     <= '0;
            tmo_cnt      <= '0;
            tick_cnt     <= '0;
            pending      <= 1'b0;
            x_buf        <= 8'h00;
            spi_start    <= 1'b0;
            spi_tx_byte  <= 8'h00;
            spi_cs       <= 1'b1;
            x_accel      <= 8'h00;
            y_accel      <= 8'h00;
            sample_valid <= 1'b0;
            config_done  <= 1'b0;
            error        <= 1'b0;
        end else begin
            spi_start    <= 1'b0;
            sample_valid <= 1'b0;
            // Update timer only runs while configured and restarts from 0.
            if (config_done)
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            else
                tick_cnt <= '0;
            if (!config_done)
                pending <= 1'b0;
            else if (tick && state != S_WAIT_TICK)
                pending <= 1'b1;

            case (state)
                S_CS_SETUP: begin
                    spi_cs   <= 1'b0;
                    byte_idx <= 2'd0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (!spi_busy) begin
                        spi_start   <= 1'b1;
                        spi_tx_byte <= frame_byte(frame, byte_idx);
                        tmo_cnt     <= '0;
                        state       <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (spi_done) begin
                        if (frame == FR_RD && byte_idx == 2'd2)
                            x_buf <= spi_rx_byte;
                        if (last_byte) begin
                            spi_cs   <= 1'b1;
                            wait_cnt <= '0;
                            state    <= S_CS_RELEASE;
                            if (frame == FR_RD) begin
                                x_accel      <= x_buf;
                                y_accel      <= spi_rx_byte;
                                sample_valid <= 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            state    <= S_SEND;
                        end
                    end else if (tmo_hit) begin
                        // Sensor went silent: drop config and re-run bring-up.
                        spi_cs      <= 1'b1;
                        error       <= 1'b1;
                        config_done <= 1'b0;
                        frame       <= FR_SR;
                        wait_cnt    <= '0;
                        state       <= S_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_CS_RELEASE: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    state    <= (frame == FR_SR) ? S_WAIT_SR : S_GAP;
                end
                S_WAIT_SR: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt >= WW'(SOFT_RESET_WAIT_CYCLES - 1)) begin
                        frame <= FR_PWR;
                        state <= S_CS_SETUP;
                    end
                end
                S_GAP: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt >= WW'(CS_GAP_CYCLES - 1)) begin
                        if (frame == FR_SR) begin
                            state <= S_CS_SETUP;
                        end else begin
                            config_done <= 1'b1;
                            state       <= S_WAIT_TICK;
                        end
                    end
                end
                S_WAIT_TICK: begin
                    if (tick || pending) begin
                        pending <= 1'b0;
                        frame   <= FR_RD;
                        state   <= S_CS_SETUP;
                    end
                end
                default: state <= S_CS_SETUP;
            endcase
        end
    end

endmodule
